// File: rtl/regfl_rdport.sv
`default_nettype none
// ============================================================================
// Module   : regfl_rdport
// Purpose  : Read port for the 8-entry register file; serves single-word and
//            wrapping burst reads into a one-entry registered response slot.
// Revision : 1.0
// ============================================================================
module regfl_rdport #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*W-1:0] q_all,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_addr,
    input  logic [2:0]     req_len,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [2:0]     rsp_addr,
    output logic           rsp_last,
    output logic           busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]   r_state;
    logic [2:0]   r_left;
    logic [2:0]   r_next_addr;
    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_data;
    logic [2:0]   r_rsp_addr;
    logic         r_rsp_last;

    logic [W-1:0] w_words [8];
    logic         w_slot_free;
    logic         w_accept;
    logic [2:0]   w_rd_idx;
    logic [W-1:0] w_rd_word;

    // Register 0 lives in the MSBs of the flattened bus.
    for (genvar g = 0; g < 8; g++) begin : g_unpack
        assign w_words[g] = q_all[8*W-1-g*W -: W];
    end

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign req_ready   = (r_state == S_IDLE) && w_slot_free && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_rd_idx    = (r_state == S_BURST) ? r_next_addr : req_addr;
    assign w_rd_word   = w_words[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_left      <= 3'd0;
            r_next_addr <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= 3'd0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_word;
                        r_rsp_addr  <= req_addr;
                        r_rsp_last  <= (req_len == 3'd0);
                        if (req_len != 3'd0) begin
                            r_left      <= req_len;
                            r_next_addr <= req_addr + 3'd1;
                            r_state     <= S_BURST;
                        end
                    end else if (w_slot_free) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                S_BURST: begin
                    // IDLE is entered on the edge loading the last beat, so a
                    // new request can be taken while that beat is consumed.
                    if (w_slot_free) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_rd_word;
                        r_rsp_addr  <= r_next_addr;
                        r_rsp_last  <= (r_left == 3'd1);
                        r_next_addr <= r_next_addr + 3'd1;
                        r_left      <= r_left - 3'd1;
                        if (r_left == 3'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_last  = r_rsp_last;
    assign busy      = (r_state == S_BURST);

endmodule
`default_nettype wire
